// File: rtl/uart_tx_feeder_pkg.sv
// uart_tx_feeder_pkg: shared constants and FSM encoding for the UART transmit feeder
package uart_tx_feeder_pkg;
    localparam logic ENABLE       = 1'b1;
    localparam logic DISABLE      = 1'b0;
    localparam int   BYTE_W       = 8;
    localparam int   FEEDER_DEPTH = 16;
    typedef enum logic {FEEDER_IDLE = 1'b0, FEEDER_WAIT_END = 1'b1} feeder_state_t;
endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: DEPTH x byte storage, synchronous write and combinational read
module uart_fifo_ram
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH  = FEEDER_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [BYTE_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [BYTE_W-1:0] o_rdata
);
    logic [BYTE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO that issues one byte per transmitter frame, pacing on tx_end
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH  = FEEDER_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              flush,
    input  logic              clr_ovf,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              drained,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_busy,
    input  logic              tx_end
);
    feeder_state_t     r_state;
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_overflow, r_drained, r_tx_start;
    logic [BYTE_W-1:0] r_tx_data, w_rd_data;
    logic              w_full, w_empty, w_push, w_pop;

    assign w_full  = r_level == (ADDR_W+1)'(DEPTH);
    assign w_empty = r_level == '0;
    assign w_push  = wr_en && !w_full && !flush;
    assign w_pop   = r_state == FEEDER_IDLE && !w_empty && !tx_busy;

    uart_fifo_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= DISABLE;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                if (w_pop) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                r_level <= r_level + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);
            end
            // a rejected push outranks a same-cycle clear
            if (wr_en && w_full && !flush) r_overflow <= ENABLE;
            else if (clr_ovf) r_overflow <= DISABLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FEEDER_IDLE;
            r_tx_start <= DISABLE;
            r_tx_data  <= '0;
            r_drained  <= DISABLE;
        end else begin
            r_tx_start <= DISABLE;
            r_drained  <= DISABLE;
            if (r_state == FEEDER_IDLE) begin
                if (w_pop) begin
                    r_tx_data  <= w_rd_data;
                    r_tx_start <= ENABLE;
                    r_state    <= FEEDER_WAIT_END;
                end
            end else if (tx_end) begin
                r_state   <= FEEDER_IDLE;
                r_drained <= w_empty && !w_push;
            end
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign drained  = r_drained;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: randomized scenarios checked against a queue-based model of the feeder
module tb_uart_tx_feeder;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic reset, wr_en, flush, clr_ovf, tx_busy, tx_end;
    logic [7:0] wr_data, tx_data;
    logic full, empty, overflow, drained, tx_start;
    logic [AW:0] level;

    logic hold_busy;
    int   tx_cnt, frame_len;
    bit   rst_s;
    int   n_checks, n_errors, n_drained;
    bit   mon_en;

    logic [7:0] m_q[$];
    logic [7:0] sent[$];
    bit         sending, exp_start, exp_drained, m_ovf;
    logic [7:0] exp_data;

    always #5 clk = ~clk;
    assign tx_busy = hold_busy || tx_cnt != 0;

    uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
        .clr_ovf(clr_ovf), .full(full), .empty(empty), .level(level), .overflow(overflow),
        .drained(drained), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .tx_end(tx_end)
    );

    // transmitter: busy for frame_len cycles after a start, then a one-cycle tx_end
    always @(posedge clk) begin
        rst_s = reset;
        #1;
        tx_end = 1'b0;
        if (rst_s) tx_cnt = 0;
        else begin
            if (tx_cnt > 0) begin
                tx_cnt--;
                tx_end = (tx_cnt == 0);
            end
            if (tx_start === 1'b1) tx_cnt = frame_len;
        end
    end

    // reference: the FIFO is a queue, one frame in flight at most
    always @(posedge clk) begin : model
        bit full_b, pushed;
        if (reset) begin
            m_q.delete();
            sending = 0; exp_start = 0; exp_drained = 0; m_ovf = 0; exp_data = 8'h00;
        end else begin
            full_b = m_q.size() == DEPTH;
            pushed = wr_en && !flush && !full_b;
            exp_start = 0;
            exp_drained = 0;
            if (sending && tx_end) begin
                sending = 0;
                exp_drained = m_q.size() == 0 && !pushed;
            end else if (!sending && m_q.size() > 0 && !tx_busy) begin
                exp_start = 1;
                exp_data = m_q.pop_front();
                sending = 1;
            end
            if (flush) m_q.delete();
            else if (pushed) m_q.push_back(wr_data);
            if (wr_en && full_b && !flush) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
        end
    end

    always @(negedge clk) if (mon_en) begin
        n_checks += 7;
        if (tx_start !== exp_start) begin n_errors++; $display("FAIL mon_tx_start t=%0t got %b exp %b", $time, tx_start, exp_start); end
        if (tx_data !== exp_data) begin n_errors++; $display("FAIL mon_tx_data t=%0t got %h exp %h", $time, tx_data, exp_data); end
        if (level !== (AW+1)'(m_q.size())) begin n_errors++; $display("FAIL mon_level t=%0t got %0d exp %0d", $time, level, m_q.size()); end
        if (full !== (m_q.size() == DEPTH)) begin n_errors++; $display("FAIL mon_full t=%0t got %b", $time, full); end
        if (empty !== (m_q.size() == 0)) begin n_errors++; $display("FAIL mon_empty t=%0t got %b", $time, empty); end
        if (overflow !== m_ovf) begin n_errors++; $display("FAIL mon_overflow t=%0t got %b exp %b", $time, overflow, m_ovf); end
        if (drained !== exp_drained) begin n_errors++; $display("FAIL mon_drained t=%0t got %b exp %b", $time, drained, exp_drained); end
        if (tx_start === 1'b1) sent.push_back(tx_data);
        if (drained === 1'b1) n_drained++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick;
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (m_q.size() == 0 && !sending && tx_cnt == 0 && !tx_end) begin
                ok = 1;
                break;
            end
            tick;
        end
        tick;
        tick;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        mon_en = 1;
        @(negedge clk);
        n_checks += 7;
        if (level !== 5'd0) begin n_errors++; $display("FAIL reset_level got %0d exp 0", level); end
        if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full got %b exp 0", full); end
        if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        if (tx_start !== 1'b0) begin n_errors++; $display("FAIL reset_tx_start got %b exp 0", tx_start); end
        if (tx_data !== 8'h00) begin n_errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
        if (drained !== 1'b0) begin n_errors++; $display("FAIL reset_drained got %b exp 0", drained); end
        tick;
        reset = 1'b0;
    endtask

    task automatic test_single;
        int d0;
        bit ok;
        frame_len = 4;
        d0 = n_drained;
        push(8'hA5);
        @(negedge clk);
        n_checks++;
        if (tx_start !== 1'b0) begin n_errors++; $display("FAIL single_early_start got %b exp 0", tx_start); end
        tick;
        @(negedge clk);
        n_checks += 2;
        if (tx_start !== 1'b1) begin n_errors++; $display("FAIL single_latency got %b exp 1", tx_start); end
        if (tx_data !== 8'hA5) begin n_errors++; $display("FAIL single_data got %h exp a5", tx_data); end
        wait_drain(50, ok);
        n_checks += 3;
        if (!ok) begin n_errors++; $display("FAIL single_timeout got 0 exp 1"); end
        if (n_drained - d0 != 1) begin n_errors++; $display("FAIL single_drained got %0d exp 1", n_drained - d0); end
        if (empty !== 1'b1) begin n_errors++; $display("FAIL single_empty got %b exp 1", empty); end
    endtask

    task automatic test_burst;
        int n0;
        bit ok;
        frame_len = 1 + $urandom_range(0, 3);
        n0 = sent.size();
        hold_busy = 1'b1;
        for (int i = 1; i <= 16; i++) push(8'(i));
        @(negedge clk);
        n_checks += 2;
        if (full !== 1'b1) begin n_errors++; $display("FAIL burst_full got %b exp 1", full); end
        if (level !== 5'd16) begin n_errors++; $display("FAIL burst_level got %0d exp 16", level); end
        tick;
        hold_busy = 1'b0;
        wait_drain(300, ok);
        n_checks += 2;
        if (!ok) begin n_errors++; $display("FAIL burst_timeout got 0 exp 1"); end
        if (sent.size() - n0 != 16) begin n_errors++; $display("FAIL burst_count got %0d exp 16", sent.size() - n0); end
        for (int i = 0; i < 16 && n0 + i < sent.size(); i++) begin
            n_checks++;
            if (sent[n0+i] !== 8'(i + 1)) begin n_errors++; $display("FAIL burst_order idx %0d got %h exp %h", i, sent[n0+i], 8'(i + 1)); end
        end
    endtask

    task automatic test_overflow;
        int n0, nff;
        bit ok;
        frame_len = 2;
        n0 = sent.size();
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 254)));
        push(8'hFF);
        @(negedge clk);
        n_checks += 2;
        if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        if (level !== 5'd16) begin n_errors++; $display("FAIL ovf_level got %0d exp 16", level); end
        tick;
        clr_ovf = 1'b1;
        push(8'hFF);
        @(negedge clk);
        n_checks++;
        if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set_wins got %b exp 1", overflow); end
        tick;
        clr_ovf = 1'b0;
        @(negedge clk);
        n_checks++;
        if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
        tick;
        hold_busy = 1'b0;
        wait_drain(300, ok);
        nff = 0;
        for (int i = n0; i < sent.size(); i++) if (sent[i] === 8'hFF) nff++;
        n_checks += 3;
        if (!ok) begin n_errors++; $display("FAIL ovf_timeout got 0 exp 1"); end
        if (nff != 0) begin n_errors++; $display("FAIL ovf_ff_sent got %0d exp 0", nff); end
        if (sent.size() - n0 != 16) begin n_errors++; $display("FAIL ovf_count got %0d exp 16", sent.size() - n0); end
    endtask

    task automatic test_simul_wrap;
        logic [7:0] pushed[$];
        logic [7:0] d;
        int n0, cnt;
        bit ok;
        frame_len = 1;
        n0 = sent.size();
        hold_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom_range(0, 255));
            pushed.push_back(d);
            push(d);
        end
        hold_busy = 1'b0;
        d = 8'($urandom_range(0, 255));
        pushed.push_back(d);
        push(d);
        @(negedge clk);
        n_checks += 2;
        if (level !== 5'd3) begin n_errors++; $display("FAIL simul_level got %0d exp 3", level); end
        if (tx_start !== 1'b1) begin n_errors++; $display("FAIL simul_pop got %b exp 1", tx_start); end
        tick;
        cnt = 0;
        for (int c = 0; c < 2000 && cnt < 40; c++) begin
            if (m_q.size() < DEPTH && $urandom_range(0, 2) != 0) begin
                d = 8'($urandom_range(0, 255));
                wr_en = 1'b1;
                wr_data = d;
                pushed.push_back(d);
                cnt++;
            end else wr_en = 1'b0;
            tick;
        end
        wr_en = 1'b0;
        wait_drain(400, ok);
        n_checks += 2;
        if (!ok) begin n_errors++; $display("FAIL wrap_timeout got 0 exp 1"); end
        if (sent.size() - n0 != pushed.size()) begin n_errors++; $display("FAIL wrap_count got %0d exp %0d", sent.size() - n0, pushed.size()); end
        for (int i = 0; i < pushed.size() && n0 + i < sent.size(); i++) begin
            n_checks++;
            if (sent[n0+i] !== pushed[i]) begin n_errors++; $display("FAIL wrap_data idx %0d got %h exp %h", i, sent[n0+i], pushed[i]); end
        end
    endtask

    task automatic test_flush;
        logic [7:0] first;
        int n0, ns, d0;
        frame_len = 20;
        n0 = sent.size();
        d0 = n_drained;
        first = 8'($urandom_range(0, 255));
        push(first);
        for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)));
        repeat (4) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (level !== 5'd0) begin n_errors++; $display("FAIL flush_level got %0d exp 0", level); end
        if (empty !== 1'b1) begin n_errors++; $display("FAIL flush_empty got %b exp 1", empty); end
        ns = sent.size();
        for (int i = 0; i < 60 && sending; i++) tick;
        repeat (10) tick;
        n_checks += 4;
        if (sent.size() != ns || ns != n0 + 1) begin n_errors++; $display("FAIL flush_starts got %0d exp 1", sent.size() - n0); end
        if (ns > n0 && sent[n0] !== first) begin n_errors++; $display("FAIL flush_inflight got %h exp %h", sent[n0], first); end
        if (n_drained - d0 != 1) begin n_errors++; $display("FAIL flush_drained got %0d exp 1", n_drained - d0); end
        if (empty !== 1'b1) begin n_errors++; $display("FAIL flush_final_empty got %b exp 1", empty); end
    endtask

    task automatic test_reset_mid;
        int n0;
        bit ok;
        frame_len = 30;
        for (int i = 0; i < 20; i++) push(8'($urandom_range(0, 255)));
        @(negedge clk);
        n_checks += 2;
        if (overflow !== 1'b1) begin n_errors++; $display("FAIL rmid_pre_ovf got %b exp 1", overflow); end
        if (level !== 5'd16) begin n_errors++; $display("FAIL rmid_pre_level got %0d exp 16", level); end
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        @(negedge clk);
        n_checks += 3;
        if (tx_start !== 1'b0) begin n_errors++; $display("FAIL rmid_tx_start got %b exp 0", tx_start); end
        if (level !== 5'd0) begin n_errors++; $display("FAIL rmid_level got %0d exp 0", level); end
        if (overflow !== 1'b0) begin n_errors++; $display("FAIL rmid_overflow got %b exp 0", overflow); end
        tick;
        frame_len = 3;
        n0 = sent.size();
        push(8'h3C);
        wait_drain(50, ok);
        n_checks += 2;
        if (!ok || sent.size() != n0 + 1) begin n_errors++; $display("FAIL rmid_after_count got %0d exp 1", sent.size() - n0); end
        if (sent.size() > n0 && sent[n0] !== 8'h3C) begin n_errors++; $display("FAIL rmid_after_data got %h exp 3c", sent[n0]); end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; clr_ovf = 1'b0;
        hold_busy = 1'b0; tx_end = 1'b0; tx_cnt = 0; frame_len = 3;
        n_checks = 0; n_errors = 0; n_drained = 0; mon_en = 0;
        test_reset;
        test_single;
        test_burst;
        test_overflow;
        test_simul_wrap;
        test_flush;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
